// File: rtl/input_debouncer_pkg.sv
// Shared constants, types and helpers for the input debouncer.
// Mask presets cover the key (active-low) and slide-switch (active-high) input groups.
package input_debouncer_pkg;

    localparam logic [31:0] KEY_ACTIVE_LOW_MASK = 32'h0000_000F;
    localparam logic [31:0] SW_ACTIVE_LOW_MASK  = 32'h0000_0000;

    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 10;

    // Per-bit decision for one clock, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        ACT_CLEAR  = 2'd0,
        ACT_COMMIT = 2'd1,
        ACT_COUNT  = 2'd2,
        ACT_HOLD   = 2'd3
    } bit_action_e;

    // Bits needed to hold a tick count of 0..stable_ticks.
    function automatic int cnt_width(input int stable_ticks);
        int w;
        w = $clog2(stable_ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Bits needed for a prescaler counting 0..tick_div-1.
    function automatic int div_width(input int tick_div);
        int w;
        w = $clog2(tick_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_debouncer_tick_gen.sv
// Debounce prescaler: counts 0..TICK_DIV-1 and emits a registered one-cycle tick
// whenever the count sits at its last value. TICK_DIV = 1 ticks every cycle.
module debounce_tick_gen
    import input_debouncer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = div_width(TICK_DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;
    logic          tick_q;
    logic          tick_d;
    logic          at_last;

    always_comb begin
        at_last = (count_q == DIV_LAST);
        count_d = at_last ? '0 : count_q + PW'(1);
        tick_d  = at_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/input_debouncer.sv
// Input debouncer: 2-FF synchroniser, polarity normalisation and independent per-bit
// tick-window debounce. Define INPUT_DEBOUNCER_EDGE_EN to add rise/fall pulse outputs.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = '0,
    parameter int               TICK_DIV        = DEF_TICK_DIV,
    parameter int               STABLE_TICKS    = DEF_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic             tick_o
`ifdef INPUT_DEBOUNCER_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`endif
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync1_d;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] sync2_d;
    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic             tick;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Sync flops idle at the mask so a held-idle input normalises to 0 straight out of reset.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        norm    = sync2_q ^ ACTIVE_LOW_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ACTIVE_LOW_MASK;
            sync2_q <= ACTIVE_LOW_MASK;
            db_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          bit_db_d;
            bit_action_e   act;

            // Any agreement restarts the window; commit on the tick that completes it.
            always_comb begin
                if (norm[gi] == db_q[gi]) begin
                    act = ACT_CLEAR;
                end else if (tick && (cnt_q == CNT_LAST)) begin
                    act = ACT_COMMIT;
                end else if (tick) begin
                    act = ACT_COUNT;
                end else begin
                    act = ACT_HOLD;
                end
            end

            always_comb begin
                cnt_d    = cnt_q;
                bit_db_d = db_q[gi];
                unique case (act)
                    ACT_CLEAR: begin
                        cnt_d = '0;
                    end
                    ACT_COMMIT: begin
                        cnt_d    = '0;
                        bit_db_d = norm[gi];
                    end
                    ACT_COUNT: begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    ACT_HOLD: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign db_d[gi] = bit_db_d;
        end
    endgenerate

    assign db_out = db_q;
    assign tick_o = tick;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // Registered alongside db_q so each pulse lines up with the db_out transition.
    always_comb begin
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`endif

endmodule
